// File: rtl/sobel_magnitude.sv
// sobel_magnitude: L1 gradient magnitude with border mask,
// edge threshold and end-of-frame flag in a 2-stage pipe.
module sobel_magnitude #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16,
  parameter int ROWS_P  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*WIDTH_P-1:0] gx_i,
  input  logic [2*WIDTH_P-1:0] gy_i,
  input  logic [WIDTH_P-1:0]   thresh_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH_P-1:0]   mag_o,
  output logic                 edge_o,
  output logic                 last_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int RW = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(DEPTH_P - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS_P - 1);

  typedef struct packed {
    logic [GW:0]        sum;
    logic               border;
    logic               last;
    logic [WIDTH_P-1:0] thr;
  } s1_t;

  logic          s1_v;
  logic          s2_v;
  logic          s1_adv;
  logic          s2_adv;
  logic          in_hs;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;
  logic [GW-1:0] ax;
  logic [GW-1:0] ay;
  s1_t           s1_d;
  s1_t           s1_q;
  logic [WIDTH_P-1:0] sat;

  assign s2_adv  = !s2_v | ready_i;
  assign s1_adv  = !s1_v | s2_adv;
  assign ready_o = s1_adv;
  assign in_hs   = valid_i & s1_adv;
  assign valid_o = s2_v;

  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);

  // Two's-complement negate; the most negative value maps to 2^(GW-1).
  assign ax = gx_i[GW-1] ? (~gx_i + GW'(1)) : gx_i;
  assign ay = gy_i[GW-1] ? (~gy_i + GW'(1)) : gy_i;

  always_comb begin
    s1_d        = '0;
    s1_d.sum    = {1'b0, ax} + {1'b0, ay};
    s1_d.border = (row < RW'(2)) | (col < CW'(2));
    s1_d.last   = row_end & col_end;
    s1_d.thr    = thresh_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col <= '0;
      row <= '0;
    end else if (in_hs) begin
      col <= col_end ? '0 : col + CW'(1);
      if (col_end) begin
        row <= row_end ? '0 : row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (s1_adv) begin
      s1_v <= in_hs;
      if (in_hs) begin
        s1_q <= s1_d;
      end
    end
  end

  assign sat = (|s1_q.sum[GW:WIDTH_P]) ? '1 : s1_q.sum[WIDTH_P-1:0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_v   <= 1'b0;
      mag_o  <= '0;
      edge_o <= 1'b0;
      last_o <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        mag_o  <= s1_q.border ? '0 : sat;
        edge_o <= !s1_q.border && (sat >= s1_q.thr);
        last_o <= s1_q.last;
      end
    end
  end

endmodule

// File: doc/sobel_magnitude.md
# sobel_magnitude

Downstream stage of the 3x3 Sobel convolution. Consumes the signed gradient pair (gx, gy) per accepted pixel and computes the L1 magnitude |gx|+|gy|, saturated to pixel width. It masks the window warm-up border to zero, applies a binary edge threshold and flags end-of-frame. It is a 2-stage valid/ready pipeline that holds data under backpressure without loss or duplication.

## Interface
- WIDTH_P, 8, pixel width; the gradient inputs are 2*WIDTH_P bits wide.
- DEPTH_P, 16, pixels per line. Must match the upstream convolution line length.
- ROWS_P, 16, lines per frame.
- clk_i  in  1  clock; single clock domain.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  upstream gradient pair is valid.
- ready_o  out  1  block accepts the pair this cycle.
- gx_i  in  2*WIDTH_P  signed horizontal gradient.
- gy_i  in  2*WIDTH_P  signed vertical gradient.
- thresh_i  in  WIDTH_P  unsigned edge threshold. Quasi-static; sampled at the input handshake.
- valid_o  out  1  output beat is valid.
- ready_i  in  1  downstream accepts the output beat.
- mag_o  out  WIDTH_P  saturated magnitude; 0 in the border region.
- edge_o  out  1  mag_o >= thresh and the beat is not in the border region.
- last_o  out  1  beat is the final pixel of the frame.

## Operation
- Input handshake: valid_i & ready_o. Output handshake: valid_o & ready_i.
- Position counters col (0..DEPTH_P-1) and row (0..ROWS_P-1):
  - Both advance only on an input handshake.
  - col wraps to 0 at DEPTH_P-1 and row increments on that wrap.
  - row wraps to 0 on the handshake at (ROWS_P-1, DEPTH_P-1).
- Border flag: set when row < 2 or col < 2, because the upstream window does not yet hold 3 valid rows/columns there.
- Stage 1, loaded on an input handshake:
  - ax = |gx_i| and ay = |gy_i|, each unsigned 2*WIDTH_P bits. |-2^(2W-1)| = 2^(2W-1) is exact with no overflow.
  - sum = ax + ay, 2*WIDTH_P+1 bits, registered.
  - Also registered: the border flag, the last flag (row=ROWS_P-1 and col=DEPTH_P-1) and thresh_i.
- Stage 2, loaded when stage 1 advances:
  - sat = min(sum, 2^WIDTH_P-1).
  - mag_o = border ? 0 : sat.
  - edge_o = !border && (sat >= thresh).
  - last_o is the registered last flag.
- Each stage has a valid bit. A stage loads when it is empty or when its contents move on this cycle:
  - s2_adv = !s2_v | ready_i.
  - s1_adv = !s1_v | (s2_adv).
  - ready_o = s1_adv. This is a combinational path from ready_i, which is acceptable for this stage.
- A stage that is not advancing holds all of its registers unchanged, data and flags included.
- Output order equals input order. Every accepted input produces exactly one output beat.

## Timing
- Reset, asynchronous and immediate on rstn_i low:
  - s1_v, s2_v, col, row and all data registers go to 0.
  - valid_o=0, mag_o=0, edge_o=0, last_o=0.
  - ready_o=1 while the pipeline is empty.
- Latency: 2 cycles. A pair accepted at edge N appears on valid_o/mag_o after edge N+1, with ready_i held high.
- Throughput: 1 beat/cycle when ready_i stays high.
- Backpressure: with ready_i low, the pipeline absorbs at most 2 beats. ready_o then drops in the same cycle that both stages are full and ready_i is low.
- Outputs are stable while valid_o=1 and ready_i=0.
- ready_i rising while both stages are full: stage 2 drains, stage 1 moves to stage 2, and one new input is accepted, all in the same cycle.
- Frame wrap:
  - The beat after last_o restarts at (0,0) and is border-masked.
  - No idle cycle is inserted at the line or frame boundary.
- Reset mid-stream: in-flight beats are discarded and never presented. The next accepted pair is treated as (0,0).
- Exactly one last_o beat per DEPTH_P*ROWS_P accepted inputs.

## Test plan
- Reset, then rstn_i=1 with valid_i=0:
  - valid_o=0, mag_o=0, edge_o=0, last_o=0, ready_o=1.
  - No output beat for 10 cycles.
- Stream 2 rows plus 2 pixels of zeros, then an interior pixel gx=30, gy=-40, thresh=60, ready_i=1:
  - That beat gives mag_o=70, edge_o=1, exactly 2 cycles after acceptance.
  - The same pair with thresh=71 gives edge_o=0.
- Saturation at an interior pixel:
  - gx=-32768, gy=200 gives mag_o=255, edge_o=1 with thresh=255.
  - gx=255, gy=0 gives mag_o=255.
  - gx=-1, gy=1 gives mag_o=2.
- Border masking: drive gx=gy=100 on every pixel of a 16x16 frame, thresh=10.
  - Outputs for row<2 or col<2 have mag_o=0, edge_o=0.
  - (2,2) has mag_o=200.
  - (2,1) has mag_o=0.
- Backpressure: continuous valid_i with ready_i toggling randomly, including 5-cycle low bursts.
  - ready_o falls after 2 unconsumed beats.
  - The output sequence matches the reference model in order, with no loss or duplication.
  - last_o is asserted only on beat 256, then again on beat 512.
- Assert rstn_i low for 1 cycle mid-row, with beats in flight:
  - valid_o drops immediately and no stale beats appear.
  - The next frame masks rows 0-1 and its last_o falls on the 256th post-reset beat.
